// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues one I-cache request per PC, loads the IF/ID
// register, holds one response while decode stalls, and discards responses
// made stale by a redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_in,
    output logic        pc_write,
    input  logic        flush,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_ready,
    input  logic        icache_valid,
    input  logic [31:0] icache_data,
    input  logic        icache_exc,
    input  logic        stall_id,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_exc
);

    typedef enum logic [1:0] {StReq, StWait, StHold, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        hold_exc_q, hold_exc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_exc_q, ifid_exc_d;

    logic        accept;
    logic [31:0] resp_instr;

    assign icache_addr = pc_in;
    assign accept      = !ifid_valid_q || !stall_id;
    // Faulted fetches deliver a NOP so decode never sees garbage bits.
    assign resp_instr  = icache_exc ? NOP_INSTR : icache_data;

    // Next-state, IF/ID load and PC-advance decisions.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        hold_exc_d   = hold_exc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_exc_d   = ifid_exc_q;
        pc_write     = 1'b0;
        icache_req   = 1'b0;

        // Decode consumed the entry, or a redirect kills it.
        if (ifid_valid_q && !stall_id) ifid_valid_d = 1'b0;
        if (flush) ifid_valid_d = 1'b0;

        unique case (state_q)
            StReq: begin
                icache_req = !flush;
                if (flush) begin
                    pc_write = 1'b1;
                end else if (icache_ready) begin
                    fetch_pc_d = pc_in;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (flush) begin
                    pc_write = 1'b1;
                    // A same-cycle response is already gone; nothing left to drop.
                    state_d  = icache_valid ? StReq : StDrop;
                end else if (icache_valid) begin
                    if (accept) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = fetch_pc_q;
                        ifid_instr_d = resp_instr;
                        ifid_exc_d   = icache_exc;
                        pc_write     = 1'b1;
                        state_d      = StReq;
                    end else begin
                        hold_pc_d    = fetch_pc_q;
                        hold_instr_d = resp_instr;
                        hold_exc_d   = icache_exc;
                        state_d      = StHold;
                    end
                end
            end
            StHold: begin
                if (flush) begin
                    pc_write = 1'b1;
                    state_d  = StReq;
                end else if (accept) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = hold_pc_q;
                    ifid_instr_d = hold_instr_q;
                    ifid_exc_d   = hold_exc_q;
                    pc_write     = 1'b1;
                    state_d      = StReq;
                end
            end
            StDrop: begin
                // The PC was already redirected, so the discard does not advance it.
                if (flush) pc_write = 1'b1;
                if (icache_valid) state_d = StReq;
            end
            default: state_d = StReq;
        endcase

        if (!reset_n) begin
            icache_req = 1'b0;
            pc_write   = 1'b0;
        end
    end

    // All stage state, cleared asynchronously together with the I-cache.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StReq;
            fetch_pc_q   <= RESET_PC;
            hold_pc_q    <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            hold_exc_q   <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_exc_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_exc_q   <= hold_exc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_exc_q   <= ifid_exc_d;
        end
    end

    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_exc   = ifid_exc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors with literal checks, plus a
// transaction-level model (outstanding fetch, pending response, IF/ID entry)
// compared against the DUT on every cycle.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_1000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc_in;
    logic        pc_write;
    logic        flush;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic        icache_valid;
    logic [31:0] icache_data;
    logic        icache_exc;
    logic        stall_id;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_exc;

    int total = 0;
    int bad   = 0;
    int pw_cnt = 0;
    logic seen_bad = 1'b0;
    logic rst_seen = 1'b0;

    // Model: one outstanding fetch (m_out, possibly killed), a pending response
    // waiting for decode room, and the entry decode currently sees.
    logic        m_out, m_kill, m_pend, m_ifv, m_ifexc, m_pdexc;
    logic [31:0] m_pc, m_ifpc, m_ifinstr, m_pdpc, m_pdinstr;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_in       (pc_in),
        .pc_write    (pc_write),
        .flush       (flush),
        .icache_req  (icache_req),
        .icache_addr (icache_addr),
        .icache_ready(icache_ready),
        .icache_valid(icache_valid),
        .icache_data (icache_data),
        .icache_exc  (icache_exc),
        .stall_id    (stall_id),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr),
        .ifid_exc    (ifid_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remember reset pulses that fall entirely between two model updates.
    always @(negedge reset_n) rst_seen = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mclear();
        m_out = 0; m_kill = 0; m_pend = 0; m_ifv = 0;
        m_ifpc = RESET_PC; m_ifinstr = NOP_INSTR; m_ifexc = 0;
        m_pc = RESET_PC; m_pdpc = RESET_PC; m_pdinstr = NOP_INSTR; m_pdexc = 0;
    endtask

    task automatic mload(input logic [31:0] p, input logic [31:0] ins, input logic e);
        m_ifv = 1; m_ifpc = p; m_ifinstr = ins; m_ifexc = e;
    endtask

    // One clock edge of fetch behaviour, from inputs sampled just before it.
    task automatic mstep();
        logic        acc;
        logic [31:0] ins;
        acc = !m_ifv || !stall_id;
        ins = icache_exc ? NOP_INSTR : icache_data;
        if (m_ifv && !stall_id) m_ifv = 0;
        if (flush) begin
            m_ifv  = 0;
            m_pend = 0;
            if (m_out) begin
                if (icache_valid) begin
                    m_out = 0; m_kill = 0;
                end else begin
                    m_kill = 1;
                end
            end
        end else if (m_out && icache_valid) begin
            m_out = 0;
            if (m_kill) m_kill = 0;
            else if (acc) mload(m_pc, ins, icache_exc);
            else begin
                m_pend = 1; m_pdpc = m_pc; m_pdinstr = ins; m_pdexc = icache_exc;
            end
        end else if (m_pend && acc) begin
            m_pend = 0;
            mload(m_pdpc, m_pdinstr, m_pdexc);
        end else if (!m_out && !m_pend && icache_ready) begin
            m_out = 1;
            m_pc  = pc_in;
        end
    endtask

    // Per-cycle compare at the falling edge, model update at the rising edge.
    initial begin : compare
        logic exp_req, exp_pw, acc;
        mclear();
        forever begin
            @(negedge clk);
            if (!reset_n) mclear();
            acc     = !m_ifv || !stall_id;
            exp_req = reset_n && !flush && !m_out && !m_pend;
            exp_pw  = reset_n && (flush ||
                      (acc && ((m_out && !m_kill && icache_valid) || m_pend)));
            check("icache_req", 32'(icache_req), 32'(exp_req));
            check("pc_write", 32'(pc_write), 32'(exp_pw));
            if (exp_req) check("icache_addr", icache_addr, pc_in);
            check("ifid_valid", 32'(ifid_valid), 32'(m_ifv));
            check("ifid_pc", ifid_pc, m_ifpc);
            check("ifid_instr", ifid_instr, m_ifinstr);
            check("ifid_exc", 32'(ifid_exc), 32'(m_ifexc));
            if (pc_write) pw_cnt++;
            if (ifid_valid && ifid_instr == 32'hDEAD_BEEF) seen_bad = 1'b1;
            @(posedge clk);
            if (!reset_n || rst_seen) begin
                mclear();
                rst_seen = 1'b0;
            end
            if (reset_n) mstep();
        end
    end

    // Drive one cycle of inputs and return just after the following edge.
    task automatic cyc(input logic f, input logic rdy, input logic v, input logic [31:0] d,
                       input logic e, input logic st);
        flush = f; icache_ready = rdy; icache_valid = v; icache_data = d;
        icache_exc = e; stall_id = st;
        @(posedge clk);
        #2;
    endtask

    initial begin : stim
        reset_n = 0; pc_in = 32'h1000; flush = 0; icache_ready = 0; icache_valid = 0;
        icache_data = 0; icache_exc = 0; stall_id = 0;
        repeat (2) @(posedge clk);
        #2;
        check("rst ifid_valid", 32'(ifid_valid), 32'd0);
        check("rst ifid_pc", ifid_pc, 32'h1000);
        check("rst ifid_instr", ifid_instr, 32'h0);
        check("rst icache_req", 32'(icache_req), 32'd0);
        check("rst pc_write", 32'(pc_write), 32'd0);
        reset_n = 1;
        #1;
        check("req after release", 32'(icache_req), 32'd1);

        // First fetch: request, one idle cycle, response.
        pw_cnt = 0;
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h8C01_0004, 0, 0);
        check("t1 valid", 32'(ifid_valid), 32'd1);
        check("t1 pc", ifid_pc, 32'h1000);
        check("t1 instr", ifid_instr, 32'h8C01_0004);
        check("t1 pc_write pulses", pw_cnt, 1);

        // I-cache not ready for four cycles.
        pc_in = 32'h1004;
        pw_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            check("t4 req held", 32'(icache_req), 32'd1);
            check("t4 addr", icache_addr, 32'h1004);
        end
        check("t4 no pc_write", pw_cnt, 0);
        check("t4 ifid drained", 32'(ifid_valid), 32'd0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h00A0_0093, 0, 0);
        check("t4 pc", ifid_pc, 32'h1004);

        // Faulted fetch.
        pc_in = 32'h1008;
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h1234_5678, 1, 0);
        check("t5 instr nop", ifid_instr, NOP_INSTR);
        check("t5 exc", 32'(ifid_exc), 32'd1);
        check("t5 pc", ifid_pc, 32'h1008);

        // Response arrives while decode is stalled.
        pc_in = 32'h100C;
        cyc(0, 1, 0, 0, 0, 1);
        pw_cnt = 0;
        cyc(0, 0, 1, 32'h2042_0001, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 1);
            check("t2 stable pc", ifid_pc, 32'h1008);
            check("t2 stable valid", 32'(ifid_valid), 32'd1);
            check("t2 no req", 32'(icache_req), 32'd0);
        end
        check("t2 no pc_write", pw_cnt, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("t2 instr", ifid_instr, 32'h2042_0001);
        check("t2 pc", ifid_pc, 32'h100C);
        check("t2 one pc_write", pw_cnt, 1);
        pc_in = 32'h1010;
        cyc(0, 0, 0, 0, 0, 0);
        check("t2 no duplicate", 32'(ifid_valid), 32'd0);

        // Flush while waiting; the late response must vanish.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        pc_in = 32'h2000;
        cyc(0, 1, 0, 0, 0, 0);
        check("t3 no req in drop", 32'(icache_req), 32'd0);
        cyc(0, 0, 1, 32'hDEAD_BEEF, 0, 0);
        check("t3 dropped", 32'(ifid_valid), 32'd0);
        check("t3 req new pc", 32'(icache_req), 32'd1);
        check("t3 addr", icache_addr, 32'h2000);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h0000_0013, 0, 0);
        check("t3 new pc", ifid_pc, 32'h2000);
        check("t3 new instr", ifid_instr, 32'h0000_0013);

        // Reset pulse between edges while a fetch is outstanding.
        pc_in = 32'h2004;
        cyc(0, 1, 0, 0, 0, 1);
        check("t6 pre valid", 32'(ifid_valid), 32'd1);
        #1;
        reset_n = 0; icache_ready = 0; stall_id = 0;
        #1;
        check("t6 valid clr", 32'(ifid_valid), 32'd0);
        check("t6 pc", ifid_pc, RESET_PC);
        check("t6 req off", 32'(icache_req), 32'd0);
        #3;
        reset_n = 1;
        @(posedge clk);
        #2;
        check("t6 req after", 32'(icache_req), 32'd1);

        // Flush and response in the same WAIT cycle go straight back to REQ.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'hBAD0_BAD0, 0, 0);
        pc_in = 32'h3000;
        cyc(0, 0, 0, 0, 0, 0);
        check("sf req", 32'(icache_req), 32'd1);
        check("sf addr", icache_addr, 32'h3000);
        check("sf empty", 32'(ifid_valid), 32'd0);

        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        check("deadbeef never seen", 32'(seen_bad), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
